// File: rtl/out_n_clock.sv
// out_n_clock: periodic output generator.
// A free-running modulo-N cycle counter drives a registered output that is
// either a one-cycle high pulse every N clocks (default) or, when the macro
// OUT_N_CLOCK_SQUARE_EN is defined, a 50%-duty square wave of period 2N that
// toggles each time the counter wraps.
// Reset is asynchronous and active-low; out always comes straight from a flop.
module out_n_clock #(
   parameter int unsigned N     = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic clock,
   input  logic reset_,
   output logic out
);

   // Reject parameter sets that cannot work: N outside 2..65535, or a counter
   // too narrow to hold N-1.
   if (N < 2 || N > 65535) begin : g_bad_n
      $error("out_n_clock: N=%0d outside legal range 2..65535", N);
   end
   if (CNT_W < 1 || CNT_W > 31 || ((N - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
      $error("out_n_clock: CNT_W=%0d cannot hold N-1=%0d", CNT_W, N - 1);
   end

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   logic [CNT_W-1:0] cnt;
   logic             wrap;

   // Wrap condition uses the counter value before the edge, so out lags the
   // wrap by exactly one edge.
   assign wrap = (cnt == LAST);

   // Modulo-N cycle counter: 0..N-1, then back to 0.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would let out see the already-updated cnt.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         cnt <= '0;
      end else if (wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

`ifdef OUT_N_CLOCK_SQUARE_EN
   // Square mode: flip the output on every counter wrap (edges N, 2N, ...).
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         out <= 1'b0;
      end else if (wrap) begin
         out <= ~out;
      end
   end
`else
   // Pulse mode: high for exactly the cycle following each counter wrap.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         out <= 1'b0;
      end else begin
         out <= wrap;
      end
   end
`endif

endmodule

// File: tb/tb_out_n_clock.sv
// tb_out_n_clock: directed bench for out_n_clock.
// Three instances (N=4, N=2, N=7) share one clock. The expected output after
// rising edge e (edges numbered from 1 after reset release) comes from a small
// closed-form model that follows OUT_N_CLOCK_SQUARE_EN like the design does.
module tb_out_n_clock;

   logic clock = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   logic out4, out2, out7;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   out_n_clock #(.N(4), .CNT_W(16)) dut4 (
      .clock  (clock),
      .reset_ (rst_a),
      .out    (out4)
   );

   out_n_clock #(.N(2), .CNT_W(16)) dut2 (
      .clock  (clock),
      .reset_ (rst_b),
      .out    (out2)
   );

   out_n_clock #(.N(7), .CNT_W(16)) dut7 (
      .clock  (clock),
      .reset_ (rst_b),
      .out    (out7)
   );

   // Expected out after counted edge e for period n.
   function automatic logic exp_out(int n, int e);
`ifdef OUT_N_CLOCK_SQUARE_EN
      return ((e / n) % 2) == 1;
`else
      return (e >= n) && ((e % n) == 0);
`endif
   endfunction

   // Reset holds out and cnt at 0 for 20 time units, across clock edges.
   task automatic test_reset();
      #1 rst_a = 1'b0;
      rst_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #5;
         checks++;
         if (out4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_out t=%0t got=%b want=0", $time, out4);
         end
         checks++;
         if (dut4.cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt t=%0t got=%0d want=0", $time, dut4.cnt);
         end
      end
   endtask

   // Release reset between edges, then follow 15 edges of the N=4 instance.
   task automatic test_pulse_train();
      @(negedge clock);
      rst_a = 1'b1;
      for (int e = 1; e <= 15; e++) begin
         @(posedge clock);
         #1;
         checks++;
         if (out4 !== exp_out(4, e)) begin
            failures++;
            $display("FAIL train_out edge=%0d got=%b want=%b", e, out4, exp_out(4, e));
         end
         checks++;
         if (dut4.cnt !== 16'(e % 4)) begin
            failures++;
            $display("FAIL train_cnt edge=%0d got=%0d want=%0d", e, dut4.cnt, e % 4);
         end
      end
   endtask

   // Assert reset asynchronously while out=1, then check the restart.
   task automatic test_mid_reset();
      @(negedge clock);
      rst_a = 1'b0;
      @(negedge clock);
      rst_a = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clock);
         #1;
      end
      checks++;
      if (out4 !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre_high got=%b want=1", out4);
      end
      #2 rst_a = 1'b0;
      #1;
      checks++;
      if (out4 !== 1'b0) begin
         failures++;
         $display("FAIL mid_async_clear got=%b want=0", out4);
      end
      checks++;
      if (dut4.cnt !== 16'd0) begin
         failures++;
         $display("FAIL mid_async_cnt got=%0d want=0", dut4.cnt);
      end
      @(posedge clock);
      #1;
      checks++;
      if (out4 !== 1'b0) begin
         failures++;
         $display("FAIL mid_held got=%b want=0", out4);
      end
      @(negedge clock);
      rst_a = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         @(posedge clock);
         #1;
         checks++;
         if (out4 !== exp_out(4, e)) begin
            failures++;
            $display("FAIL mid_restart edge=%0d got=%b want=%b", e, out4, exp_out(4, e));
         end
      end
   endtask

   // N=2 and N=7 run side by side for 22 edges.
   task automatic test_sweep();
      @(negedge clock);
      rst_b = 1'b1;
      for (int e = 1; e <= 22; e++) begin
         @(posedge clock);
         #1;
         checks++;
         if (out2 !== exp_out(2, e)) begin
            failures++;
            $display("FAIL sweep_n2 edge=%0d got=%b want=%b", e, out2, exp_out(2, e));
         end
         checks++;
         if (out7 !== exp_out(7, e)) begin
            failures++;
            $display("FAIL sweep_n7 edge=%0d got=%b want=%b", e, out7, exp_out(7, e));
         end
      end
   endtask

   initial begin
      test_reset();
      test_pulse_train();
      test_mid_reset();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
